alu_exec_unit: RTL

ALU_EXEC_UNIT -- requirements
Module: alu_exec_unit

---
 rtl/alu_exec_unit.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/alu_exec_unit.sv
// Single-issue ALU with registered result and an optional iterative shift-add multiplier.
// Define ALU_MUL_EN to build the multiplier; otherwise funct 2 decodes as illegal.
module alu_exec_unit #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             valid_in,
  output logic             ready_in,
  input  logic [1:0]       ALUop,
  input  logic [5:0]       funct,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             valid_out,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             illegal,
  output logic             stall
);

  localparam int unsigned ShW = $clog2(WIDTH);

  localparam logic [1:0] OpRType = 2'b00;
  localparam logic [1:0] OpSub   = 2'b01;
  localparam logic [1:0] OpAdd   = 2'b10;

  localparam logic [5:0] FnAdd = 6'h00;
  localparam logic [5:0] FnSub = 6'h01;
  localparam logic [5:0] FnMul = 6'h02;
  localparam logic [5:0] FnSrl = 6'h03;
  localparam logic [5:0] FnSll = 6'h04;
  localparam logic [5:0] FnAnd = 6'h05;
  localparam logic [5:0] FnOr  = 6'h06;
  localparam logic [5:0] FnSlt = 6'h2A;

  logic             accept;
  logic             is_mul;
  logic             comb_ill;
  logic [WIDTH-1:0] comb_res;
  logic [ShW-1:0]   shamt;
  logic             slt_bit;

  assign accept  = valid_in & ready_in;
  assign stall   = valid_in & ~ready_in;
  assign shamt   = b[ShW-1:0];
  assign slt_bit = $signed(a) < $signed(b);

  // Single-cycle datapath; illegal encodings leave comb_res at zero.
  always_comb begin
    comb_res = '0;
    comb_ill = 1'b0;
    is_mul   = 1'b0;
    unique case (ALUop)
      OpRType: begin
        case (funct)
          FnAdd: comb_res = a + b;
          FnSub: comb_res = a - b;
          FnMul: begin
`ifdef ALU_MUL_EN
            is_mul   = 1'b1;
`else
            comb_ill = 1'b1;
`endif
          end
          FnSrl:   comb_res = a >> shamt;
          FnSll:   comb_res = a << shamt;
          FnAnd:   comb_res = a & b;
          FnOr:    comb_res = a | b;
          FnSlt:   comb_res = {{(WIDTH-1){1'b0}}, slt_bit};
          default: comb_ill = 1'b1;
        endcase
      end
      OpAdd:   comb_res = a + b;
      OpSub:   comb_res = a - b;
      default: comb_ill = 1'b1;
    endcase
  end

`ifdef ALU_MUL_EN
  localparam logic [0:0]     StIdle  = 1'b0;
  localparam logic [0:0]     StMul   = 1'b1;
  localparam logic [ShW-1:0] CntLast = ShW'(WIDTH - 1);

  logic [0:0]       state_q;
  logic [ShW-1:0]   cnt_q;
  logic [WIDTH-1:0] mcand_q;
  logic [WIDTH-1:0] mplier_q;
  logic [WIDTH-1:0] acc_q;
  logic [WIDTH-1:0] acc_nxt;
  logic             mul_done;

  assign ready_in = (state_q == StIdle);
  assign acc_nxt  = mplier_q[0] ? acc_q + mcand_q : acc_q;
  assign mul_done = (state_q == StMul) && (cnt_q == CntLast);

  // One multiplier bit per edge; operands are captured at acceptance.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
    end else begin
      case (state_q)
        StIdle: begin
          if (accept && is_mul) begin
            state_q  <= StMul;
            cnt_q    <= '0;
            acc_q    <= '0;
            mcand_q  <= a;
            mplier_q <= b;
          end
        end
        StMul: begin
          acc_q    <= acc_nxt;
          mcand_q  <= mcand_q << 1;
          mplier_q <= mplier_q >> 1;
          if (cnt_q == CntLast) begin
            state_q <= StIdle;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: begin
          state_q <= StIdle;
          cnt_q   <= '0;
        end
      endcase
    end
  end
`else
  assign ready_in = 1'b1;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_out <= 1'b0;
      result    <= '0;
      zero      <= 1'b1;
      illegal   <= 1'b0;
    end else begin
      valid_out <= 1'b0;
      if (accept && !is_mul) begin
        valid_out <= 1'b1;
        result    <= comb_res;
        zero      <= (comb_res == '0);
        illegal   <= comb_ill;
      end
`ifdef ALU_MUL_EN
      else if (mul_done) begin
        valid_out <= 1'b1;
        result    <= acc_nxt;
        zero      <= (acc_nxt == '0);
        illegal   <= 1'b0;
      end
`endif
    end
  end

endmodule
